sram_req_responder: RTL and testbench

//  Memory-side responder for the FIFO-to-SRAM read/write controller. Accepts burst write

---
 rtl/sram_req_responder.sv | 153 +++++++++++++++
 tb/tb_sram_req_responder.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_responder.sv
// sram_req_responder: memory-side responder that queues burst write/read
// requests in arrival order, issues them one per cycle to the SRAM
// controller, and returns per-chip read data with per-chip valids.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   cal_done          SRAM calibration complete (gates issue only)
//   wr_data/wr_addr   write burst data/address, strobed by wr_req
//   rd_addr           read burst address, strobed by rd_req
//   sram_write_full   registered back-pressure (count >= DEPTH-FULL_MARGIN)
//   sram_read_full    same value as sram_write_full
//   rd_data/rd_valid  registered per-chip read return
//   mem_cmd_*         command port to the SRAM controller (valid/ready)
//   mem_rd_data/valid per-chip read data from the controller
//   err_overflow      sticky: a request was dropped for lack of space
module sram_req_responder #(
   parameter int MEM_WIDTH       = 36,
   parameter int NUM_MEM_CHIPS   = 3,
   parameter int MEM_ADDR_WIDTH  = 19,
   parameter int DEPTH_BITS      = 4,
   parameter int FULL_MARGIN     = 4,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic                                     cal_done,
   input  logic [2*MEM_WIDTH*NUM_MEM_CHIPS-1:0]     wr_data,
   input  logic [MEM_ADDR_WIDTH-1:0]                wr_addr,
   input  logic                                     wr_req,
   output logic                                     sram_write_full,
   input  logic [MEM_ADDR_WIDTH-1:0]                rd_addr,
   input  logic                                     rd_req,
   output logic                                     sram_read_full,
   output logic [2*MEM_WIDTH*NUM_MEM_CHIPS-1:0]     rd_data,
   output logic [NUM_MEM_CHIPS-1:0]                 rd_valid,
   output logic                                     mem_cmd_valid,
   output logic                                     mem_cmd_rnw,
   output logic [MEM_ADDR_WIDTH-1:0]                mem_cmd_addr,
   output logic [2*MEM_WIDTH*NUM_MEM_CHIPS-1:0]     mem_cmd_wdata,
   input  logic                                     mem_cmd_ready,
   input  logic [2*MEM_WIDTH*NUM_MEM_CHIPS-1:0]     mem_rd_data,
   input  logic [NUM_MEM_CHIPS-1:0]                 mem_rd_valid,
   output logic                                     err_overflow
);

   localparam int CW    = 2 * MEM_WIDTH;
   localparam int DW    = CW * NUM_MEM_CHIPS;
   localparam int DEPTH = 1 << DEPTH_BITS;

   typedef logic [DEPTH_BITS:0]   cnt_t;
   typedef logic [DEPTH_BITS-1:0] ptr_t;

   localparam cnt_t       DEPTH_C = cnt_t'(DEPTH);
   localparam cnt_t       FULL_C  = cnt_t'(DEPTH - FULL_MARGIN);
   localparam logic [2:0] MAX_C   = 3'(MAX_OUTSTANDING);

   typedef struct packed {
      logic                      rnw;
      logic [MEM_ADDR_WIDTH-1:0] addr;
      logic [DW-1:0]             wdata;
   } cmd_t;

   cmd_t fifo_q [DEPTH];
   ptr_t wr_ptr;
   ptr_t rd_ptr;
   ptr_t rd_slot;
   cnt_t count;
   cnt_t space;
   cnt_t rd_need;
   cmd_t head;

   logic wr_ok;
   logic rd_ok;
   logic empty;
   logic pop;
   logic rd_issue;
   logic credit_ok;
   logic full_q;

   logic [2:0]               out_cnt [NUM_MEM_CHIPS];
   logic [NUM_MEM_CHIPS-1:0] ret;

   // Free space is judged on the registered count; a same-cycle pop does
   // not make room for a push. The write claims a slot before the read.
   always_comb begin
      space   = DEPTH_C - count;
      wr_ok   = wr_req && (space != '0);
      rd_need = cnt_t'(wr_ok) + cnt_t'(1);
      rd_ok   = rd_req && (space >= rd_need);
      rd_slot = wr_ptr + ptr_t'(wr_ok);
      empty   = (count == '0);
      head    = fifo_q[rd_ptr];
   end

   always_comb begin
      credit_ok = 1'b1;
      for (int i = 0; i < NUM_MEM_CHIPS; i++) begin
         if (out_cnt[i] >= MAX_C) credit_ok = 1'b0;
      end
   end

   // Head fields are masked while empty so the port reads 0 out of reset.
   always_comb begin
      mem_cmd_valid = !empty && cal_done && (!head.rnw || credit_ok);
      mem_cmd_rnw   = !empty && head.rnw;
      mem_cmd_addr  = empty ? '0 : head.addr;
      mem_cmd_wdata = empty ? '0 : head.wdata;
      pop           = mem_cmd_valid && mem_cmd_ready;
      rd_issue      = pop && head.rnw;
   end

   always_ff @(posedge clk) begin
      if (wr_ok) fifo_q[wr_ptr] <= '{1'b0, wr_addr, wr_data};
      if (rd_ok) fifo_q[rd_slot] <= '{1'b1, rd_addr, '0};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         full_q       <= 1'b0;
         err_overflow <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr + ptr_t'(wr_ok) + ptr_t'(rd_ok);
         rd_ptr <= rd_ptr + ptr_t'(pop);
         count  <= count + cnt_t'(wr_ok) + cnt_t'(rd_ok) - cnt_t'(pop);
         full_q <= (count >= FULL_C);
         if ((wr_req && !wr_ok) || (rd_req && !rd_ok)) err_overflow <= 1'b1;
      end
   end

   assign sram_write_full = full_q;
   assign sram_read_full  = full_q;

   // Returns with no read outstanding on that chip are stale and ignored.
   for (genvar g = 0; g < NUM_MEM_CHIPS; g++) begin : g_chip
      assign ret[g] = mem_rd_valid[g] && (out_cnt[g] != '0);

      always_ff @(posedge clk) begin
         if (reset) begin
            out_cnt[g]          <= '0;
            rd_valid[g]         <= 1'b0;
            rd_data[g*CW +: CW] <= '0;
         end else begin
            out_cnt[g]  <= out_cnt[g] + 3'(rd_issue) - 3'(ret[g]);
            rd_valid[g] <= ret[g];
            if (ret[g]) rd_data[g*CW +: CW] <= mem_rd_data[g*CW +: CW];
         end
      end
   end

endmodule

// File: tb/tb_sram_req_responder.sv
// tb_sram_req_responder: directed + randomized bench for sram_req_responder
// against a queue-based reference model of the command stream and credits.
module tb_sram_req_responder;

   localparam int DW = 216;
   localparam int AW = 19;

   logic          clk = 1'b0;
   logic          reset;
   logic          cal_done;
   logic [DW-1:0] wr_data;
   logic [AW-1:0] wr_addr;
   logic          wr_req;
   logic          sram_write_full;
   logic [AW-1:0] rd_addr;
   logic          rd_req;
   logic          sram_read_full;
   logic [DW-1:0] rd_data;
   logic [2:0]    rd_valid;
   logic          mem_cmd_valid;
   logic          mem_cmd_rnw;
   logic [AW-1:0] mem_cmd_addr;
   logic [DW-1:0] mem_cmd_wdata;
   logic          mem_cmd_ready;
   logic [DW-1:0] mem_rd_data;
   logic [2:0]    mem_rd_valid;
   logic          err_overflow;

   sram_req_responder dut (
      .clk             (clk),
      .reset           (reset),
      .cal_done        (cal_done),
      .wr_data         (wr_data),
      .wr_addr         (wr_addr),
      .wr_req          (wr_req),
      .sram_write_full (sram_write_full),
      .rd_addr         (rd_addr),
      .rd_req          (rd_req),
      .sram_read_full  (sram_read_full),
      .rd_data         (rd_data),
      .rd_valid        (rd_valid),
      .mem_cmd_valid   (mem_cmd_valid),
      .mem_cmd_rnw     (mem_cmd_rnw),
      .mem_cmd_addr    (mem_cmd_addr),
      .mem_cmd_wdata   (mem_cmd_wdata),
      .mem_cmd_ready   (mem_cmd_ready),
      .mem_rd_data     (mem_rd_data),
      .mem_rd_valid    (mem_rd_valid),
      .err_overflow    (err_overflow)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          rnw;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } cmd_t;

   // reference model state
   cmd_t          m_q [$];
   int            m_cnt [3];
   logic          m_full;
   logic          m_err;
   logic [2:0]    m_rdv;
   logic [DW-1:0] m_rdd;
   logic [DW-1:0] sram_img [int];
   logic [DW-1:0] resp_q [$];
   logic [DW-1:0] exp_q [$];

   int   tests = 0;
   int   fails = 0;
   int   n_issue;
   int   ret_seen;
   logic chk_en;
   logic auto_resp;
   logic track;

   task automatic chk(input string tag, input logic [DW-1:0] obs,
                      input logic [DW-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rnd216();
      logic [DW-1:0] d = '0;
      for (int i = 0; i < 7; i++) d = (d << 32) | DW'($urandom());
      return d;
   endfunction

   function automatic logic m_valid();
      logic ok = 1'b1;
      if (m_q.size() == 0 || !cal_done) return 1'b0;
      if (!m_q[0].rnw) return 1'b1;
      for (int i = 0; i < 3; i++) if (m_cnt[i] >= 4) ok = 1'b0;
      return ok;
   endfunction

   task automatic step();
      logic v;
      logic pop;
      logic rd_iss;
      int   sz;
      cmd_t c;
      if (auto_resp) begin
         if (resp_q.size() > 0) begin
            mem_rd_valid = 3'b111;
            mem_rd_data  = resp_q.pop_front();
         end else begin
            mem_rd_valid = 3'b000;
         end
      end
      @(negedge clk);
      v = m_valid();
      if (chk_en) begin
         chk("cmd_valid", mem_cmd_valid, v);
         if (v) begin
            chk("cmd_rnw", mem_cmd_rnw, m_q[0].rnw);
            chk("cmd_addr", mem_cmd_addr, m_q[0].addr);
            if (!m_q[0].rnw) chk("cmd_wdata", mem_cmd_wdata, m_q[0].data);
         end
         chk("wr_full", sram_write_full, m_full);
         chk("rd_full", sram_read_full, m_full);
         chk("err_ovf", err_overflow, m_err);
         chk("rd_valid", rd_valid, m_rdv);
         chk("rd_data", rd_data, m_rdd);
      end
      if (mem_cmd_valid && mem_cmd_ready) n_issue++;
      if (reset) begin
         m_q.delete();
         resp_q.delete();
         for (int i = 0; i < 3; i++) m_cnt[i] = 0;
         m_full = 1'b0;
         m_err  = 1'b0;
         m_rdv  = 3'b000;
         m_rdd  = '0;
      end else begin
         sz     = m_q.size();
         pop    = v && mem_cmd_ready;
         rd_iss = pop && m_q[0].rnw;
         m_full = (sz >= 12);
         for (int i = 0; i < 3; i++) begin
            m_rdv[i] = mem_rd_valid[i] && (m_cnt[i] > 0);
            if (m_rdv[i]) m_rdd[i*72 +: 72] = mem_rd_data[i*72 +: 72];
            m_cnt[i] = m_cnt[i] + int'(rd_iss) - int'(m_rdv[i]);
         end
         if (pop) begin
            c = m_q.pop_front();
            if (!c.rnw) sram_img[int'(c.addr)] = c.data;
            else if (auto_resp)
               resp_q.push_back(sram_img.exists(int'(c.addr)) ?
                                sram_img[int'(c.addr)] : '0);
         end
         if (wr_req) begin
            if (sz < 16) begin
               m_q.push_back('{1'b0, wr_addr, wr_data});
               sz++;
            end else m_err = 1'b1;
         end
         if (rd_req) begin
            if (sz < 16) m_q.push_back('{1'b1, rd_addr, '0});
            else m_err = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      if (chk_en && track && m_rdv == 3'b111) begin
         ret_seen++;
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL rd_ret: observed unexpected return expected none");
         end else chk("rd_ret", rd_data, exp_q.pop_front());
      end
   endtask

   function automatic logic busy();
      logic b = (m_q.size() > 0) || (resp_q.size() > 0);
      for (int i = 0; i < 3; i++) if (m_cnt[i] > 0) b = 1'b1;
      return b;
   endfunction

   task automatic drain(input string tag);
      int n = 0;
      while (busy() && n < 300) begin
         if (!auto_resp) begin
            mem_rd_valid = 3'b111;
            mem_rd_data  = rnd216();
         end
         step();
         n++;
      end
      if (!auto_resp) mem_rd_valid = 3'b000;
      step();
      if (busy()) begin
         tests++;
         fails++;
         $error("FAIL %s: observed still busy expected drained", tag);
      end
   endtask

   task automatic idle(input int n);
      wr_req = 1'b0;
      rd_req = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] d;
      int            k;
      int            n;
      reset         = 1'b1;
      cal_done      = 1'b0;
      wr_data       = '0;
      wr_addr       = '0;
      wr_req        = 1'b0;
      rd_addr       = '0;
      rd_req        = 1'b0;
      mem_cmd_ready = 1'b0;
      mem_rd_data   = '0;
      mem_rd_valid  = 3'b000;
      chk_en        = 1'b0;
      auto_resp     = 1'b0;
      track         = 1'b0;
      n_issue       = 0;
      ret_seen      = 0;

      do_reset();
      chk_en = 1'b1;
      chk("rst_cmd_valid", mem_cmd_valid, 1'b0);
      chk("rst_full", sram_write_full, 1'b0);
      chk("rst_err", err_overflow, 1'b0);
      chk("rst_rd_valid", rd_valid, 3'b000);
      chk("rst_rd_data", rd_data, '0);
      chk("rst_wdata", mem_cmd_wdata, '0);

      // T1: same-cycle write + read to one address
      cal_done      = 1'b1;
      mem_cmd_ready = 1'b1;
      auto_resp     = 1'b1;
      track         = 1'b1;
      d       = rnd216();
      wr_addr = 19'h00010;
      wr_data = d;
      rd_addr = 19'h00010;
      wr_req  = 1'b1;
      rd_req  = 1'b1;
      exp_q.push_back(d);
      step();
      wr_req = 1'b0;
      rd_req = 1'b0;
      #1;
      chk("t1_wr_first", {mem_cmd_valid, mem_cmd_rnw}, 2'b10);
      step();
      chk("t1_rd_second", {mem_cmd_valid, mem_cmd_rnw}, 2'b11);
      ret_seen = 0;
      idle(3);
      chk("t1_returned", ret_seen, 1);
      auto_resp = 1'b0;
      track     = 1'b0;

      // T2: credit stall at four outstanding reads
      n_issue = 0;
      for (int i = 0; i < 6; i++) begin
         rd_addr = AW'(32'h200 + i);
         rd_req  = 1'b1;
         step();
      end
      idle(3);
      chk("t2_issued", n_issue, 4);
      chk("t2_stall", mem_cmd_valid, 1'b0);
      mem_rd_valid = 3'b111;
      mem_rd_data  = rnd216();
      step();
      mem_rd_valid = 3'b000;
      chk("t2_resume", mem_cmd_valid, 1'b1);
      step();
      chk("t2_fifth", n_issue, 5);
      drain("t2_drain");

      // T3: fill with calibration low, overflow, then ordered issue
      cal_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
         wr_addr = AW'(32'h100 + i);
         wr_data = rnd216();
         wr_req  = 1'b1;
         step();
      end
      wr_req = 1'b0;
      chk("t3_full_lag", sram_write_full, 1'b0);
      step();
      chk("t3_full", sram_write_full, 1'b1);
      for (int i = 12; i < 17; i++) begin
         wr_addr = AW'(32'h100 + i);
         wr_data = rnd216();
         wr_req  = 1'b1;
         step();
      end
      wr_req = 1'b0;
      chk("t3_overflow", err_overflow, 1'b1);
      cal_done = 1'b1;
      for (int i = 0; i < 16; i++) begin
         #1;
         chk("t3_order_v", mem_cmd_valid, 1'b1);
         chk("t3_order_a", mem_cmd_addr, AW'(32'h100 + i));
         step();
      end
      #1;
      chk("t3_empty", mem_cmd_valid, 1'b0);

      // T4: skewed per-chip return
      rd_addr = 19'h00300;
      rd_req  = 1'b1;
      step();
      idle(1);
      mem_rd_data = rnd216();
      foreach (m_cnt[i]) begin
         mem_rd_valid = (i == 0) ? 3'b001 : (i == 1) ? 3'b100 : 3'b010;
         step();
         chk("t4_skew", rd_valid, mem_rd_valid);
         mem_rd_valid = 3'b000;
         step();
      end
      mem_rd_valid = 3'b111;
      step();
      mem_rd_valid = 3'b000;
      chk("t4_cnt_zero", rd_valid, 3'b000);

      // T5: reset with queued commands and reads in flight
      for (int i = 0; i < 2; i++) begin
         rd_addr = AW'(32'h400 + i);
         rd_req  = 1'b1;
         step();
      end
      rd_req   = 1'b0;
      cal_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         wr_addr = AW'(32'h500 + i);
         wr_data = rnd216();
         wr_req  = 1'b1;
         step();
      end
      wr_req = 1'b0;
      do_reset();
      cal_done = 1'b1;
      #1;
      chk("t5_no_issue", mem_cmd_valid, 1'b0);
      mem_rd_valid = 3'b111;
      mem_rd_data  = rnd216();
      step();
      mem_rd_valid = 3'b000;
      chk("t5_stale", rd_valid, 3'b000);
      chk("t5_err_clr", err_overflow, 1'b0);

      // T6: back-to-back write/read pairs with random ready
      auto_resp = 1'b1;
      track     = 1'b1;
      ret_seen  = 0;
      k = 0;
      n = 0;
      while (k < 40 && n < 2000) begin
         mem_cmd_ready = 1'($urandom_range(0, 1));
         if (!m_full) begin
            d       = rnd216();
            wr_addr = AW'(32'h2000 + k);
            rd_addr = AW'(32'h2000 + k);
            wr_data = d;
            wr_req  = 1'b1;
            rd_req  = 1'b1;
            exp_q.push_back(d);
            k++;
         end else begin
            wr_req = 1'b0;
            rd_req = 1'b0;
         end
         step();
         n++;
      end
      wr_req = 1'b0;
      rd_req = 1'b0;
      n = 0;
      while (busy() && n < 2000) begin
         mem_cmd_ready = 1'($urandom_range(0, 1));
         step();
         n++;
      end
      mem_cmd_ready = 1'b1;
      drain("t6_drain");
      chk("t6_returns", ret_seen, 40);
      chk("t6_pending", exp_q.size(), 0);
      chk("t6_no_ovf", err_overflow, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
